register_rename: RTL and testbench

- Rename stage directly upstream of the reorder buffer.
- Maps architectural source/destination registers to physical tags and allocates a fresh tag for each destination from a free list.
- Presents one registered renamed instruction per cycle to the ROB dispatch inputs (pc, arch_rd, tag_rd, in_valid, tag_rs).
- Consumes the ROB retire outputs to update the committed map and return the superseded tag to the free list.

---
 rtl/register_rename_pkg.sv | 14 +
 rtl/register_rename_tag_free_list.sv | 52 +++++
 rtl/register_rename.sv | 101 ++++++++++
 tb/tb_register_rename.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_rename_pkg.sv
// Shared constants for the rename stage and the ROB: register/tag counts and derived widths.
package register_rename_pkg;
    localparam int NUM_REG       = 32;
    localparam int NUM_TAGS      = 64;
    localparam int NUM_REG_LOG2  = $clog2(NUM_REG);
    localparam int NUM_TAGS_LOG2 = $clog2(NUM_TAGS);
    localparam int REG_SIZE      = 32;
    localparam int FREE_DEPTH    = NUM_TAGS - NUM_REG;
    localparam int FREE_PTR_W    = $clog2(FREE_DEPTH);
    localparam int FREE_CNT_W    = $clog2(FREE_DEPTH + 1);

    typedef logic [NUM_REG_LOG2-1:0]  arch_t;
    typedef logic [NUM_TAGS_LOG2-1:0] tag_t;
endpackage

// File: rtl/register_rename_tag_free_list.sv
// Circular FIFO of unmapped physical tags; reset preloads tags NUM_REG..NUM_TAGS-1 in order.
module tag_free_list
    import register_rename_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pop,
    input  logic                  push,
    input  tag_t                  push_tag,
    output tag_t                  pop_tag,
    output logic [FREE_CNT_W-1:0] count
);
    tag_t                  mem [FREE_DEPTH];
    logic [FREE_PTR_W-1:0] head, tail;
    logic                  do_push, full;

    function automatic logic [FREE_PTR_W-1:0] next_ptr(input logic [FREE_PTR_W-1:0] p);
        return (p == FREE_PTR_W'(FREE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == FREE_CNT_W'(FREE_DEPTH));
    // A push into a full list is only legal when a pop frees a slot in the same cycle.
    assign do_push = push && (!full || pop);
    assign pop_tag = mem[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FREE_DEPTH; i++)
                mem[i] <= NUM_TAGS_LOG2'(NUM_REG + i);
            head  <= '0;
            tail  <= '0;
            count <= FREE_CNT_W'(FREE_DEPTH);
        end else begin
            if (do_push) begin
                mem[tail] <= push_tag;
                tail      <= next_ptr(tail);
            end
            if (pop)
                head <= next_ptr(head);
            if (do_push && !pop)
                count <= count + 1'b1;
            else if (pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(push && !pop && full))
            else $error("tag_free_list: push into full free list dropped");
    end
endmodule

// File: rtl/register_rename.sv
// Rename stage: speculative/commit RATs, tag allocation from the free list, one registered output per cycle.
module register_rename
    import register_rename_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_pc,
    input  arch_t                 arch_rs [0:1],
    input  arch_t                 arch_rd,
    input  logic                  rd_write,
    output logic                  in_ready,
    input  logic                  stall_in,
    output logic                  out_valid,
    output logic [7:0]            out_pc,
    output arch_t                 out_arch_rd,
    output tag_t                  out_tag_rd,
    output logic                  out_rd_alloc,
    output tag_t                  out_tag_rs [0:1],
    input  logic                  retire_valid,
    input  arch_t                 retire_reg,
    input  tag_t                  retire_tag,
    output logic [FREE_CNT_W-1:0] free_count
);
    tag_t spec_rat   [NUM_REG];
    tag_t commit_rat [NUM_REG];

    logic needs_alloc, accept, alloc, retire_push;
    tag_t pop_tag, push_tag;
    tag_t tag_rs_p0 [0:1];

    logic       vld_p1;
    logic [7:0] pc_p1;
    arch_t      arch_rd_p1;
    tag_t       tag_rd_p1;
    logic       alloc_p1;
    tag_t       tag_rs_p1 [0:1];

    assign needs_alloc = rd_write && (arch_rd != '0);
    assign in_ready    = !stall_in && (!needs_alloc || (free_count != '0));
    assign accept      = in_valid && in_ready;
    assign alloc       = accept && needs_alloc;
    assign retire_push = retire_valid && (retire_reg != '0);
    assign push_tag    = commit_rat[retire_reg];

    tag_free_list u_free_list (
        .clk      (clk),
        .rst      (rst),
        .pop      (alloc),
        .push     (retire_push),
        .push_tag (push_tag),
        .pop_tag  (pop_tag),
        .count    (free_count)
    );

    // Stage p0: source lookup sees the map before this instruction's own rd update.
    always_comb begin
        for (int i = 0; i < 2; i++)
            tag_rs_p0[i] = spec_rat[arch_rs[i]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REG; i++) begin
                spec_rat[i]   <= NUM_TAGS_LOG2'(i);
                commit_rat[i] <= NUM_TAGS_LOG2'(i);
            end
        end else begin
            if (alloc)
                spec_rat[arch_rd] <= pop_tag;
            if (retire_push)
                commit_rat[retire_reg] <= retire_tag;
        end
    end

    // Stage p1: registered renamed instruction, frozen while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            pc_p1      <= '0;
            arch_rd_p1 <= '0;
            tag_rd_p1  <= '0;
            alloc_p1   <= 1'b0;
            tag_rs_p1  <= '{default: '0};
        end else if (!stall_in) begin
            vld_p1     <= accept;
            pc_p1      <= in_pc;
            arch_rd_p1 <= arch_rd;
            tag_rd_p1  <= alloc ? pop_tag : '0;
            alloc_p1   <= alloc;
            tag_rs_p1  <= tag_rs_p0;
        end
    end

    assign out_valid    = vld_p1;
    assign out_pc       = pc_p1;
    assign out_arch_rd  = arch_rd_p1;
    assign out_tag_rd   = tag_rd_p1;
    assign out_rd_alloc = alloc_p1;
    assign out_tag_rs   = tag_rs_p1;
endmodule

// File: tb/tb_register_rename.sv
// Directed bench for register_rename: hand-computed tags, free counts and stall behaviour.
module tb_register_rename;
    import register_rename_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic [7:0]            in_pc;
    arch_t                 arch_rs [0:1];
    arch_t                 arch_rd;
    logic                  rd_write;
    logic                  in_ready;
    logic                  stall_in;
    logic                  out_valid;
    logic [7:0]            out_pc;
    arch_t                 out_arch_rd;
    tag_t                  out_tag_rd;
    logic                  out_rd_alloc;
    tag_t                  out_tag_rs [0:1];
    logic                  retire_valid;
    arch_t                 retire_reg;
    tag_t                  retire_tag;
    logic [FREE_CNT_W-1:0] free_count;

    int vectors    = 0;
    int miscompares = 0;

    register_rename dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc),
        .arch_rs(arch_rs), .arch_rd(arch_rd), .rd_write(rd_write),
        .in_ready(in_ready), .stall_in(stall_in), .out_valid(out_valid),
        .out_pc(out_pc), .out_arch_rd(out_arch_rd), .out_tag_rd(out_tag_rd),
        .out_rd_alloc(out_rd_alloc), .out_tag_rs(out_tag_rs),
        .retire_valid(retire_valid), .retire_reg(retire_reg),
        .retire_tag(retire_tag), .free_count(free_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] pc, input int rs0, input int rs1,
                         input int rd, input logic wr);
        in_valid   = v;
        in_pc      = pc;
        arch_rs[0] = arch_t'(rs0);
        arch_rs[1] = arch_t'(rs1);
        arch_rd    = arch_t'(rd);
        rd_write   = wr;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 0, 0, 0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall_in = 1'b0;
        retire_valid = 1'b0;
        retire_reg = '0;
        retire_tag = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b1, 8'h55, 3, 4, 9, 1'b1);
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b0 || out_pc !== 8'h00 || out_tag_rd !== 6'd0 || out_rd_alloc !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%0b pc=%0h tag_rd=%0d alloc=%0b required 0 0 0 0",
                     out_valid, out_pc, out_tag_rd, out_rd_alloc);
        end
        vectors++;
        if (free_count !== 6'd32 || out_tag_rs[0] !== 6'd0 || out_tag_rs[1] !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_state: got free=%0d rs={%0d,%0d} required 32 {0,0}",
                     free_count, out_tag_rs[0], out_tag_rs[1]);
        end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_basic_rename();
        do_reset();
        drive(1'b1, 8'h10, 1, 2, 3, 1'b1);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_ready: got %0b required 1", in_ready);
        end
        tick();
        idle();
        vectors++;
        if (out_valid !== 1'b1 || out_tag_rs[0] !== 6'd1 || out_tag_rs[1] !== 6'd2 ||
            out_tag_rd !== 6'd32 || out_rd_alloc !== 1'b1 || free_count !== 6'd31 ||
            out_pc !== 8'h10 || out_arch_rd !== 5'd3) begin
            miscompares++;
            $display("FAIL basic_rename: got v=%0b rs={%0d,%0d} rd=%0d alloc=%0b free=%0d pc=%0h ard=%0d required 1 {1,2} 32 1 31 10 3",
                     out_valid, out_tag_rs[0], out_tag_rs[1], out_tag_rd, out_rd_alloc,
                     free_count, out_pc, out_arch_rd);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 8'h20, 1, 2, 3, 1'b1);
        tick();
        drive(1'b1, 8'h24, 3, 3, 4, 1'b1);
        vectors++;
        if (out_tag_rd !== 6'd32) begin
            miscompares++;
            $display("FAIL b2b_first_rd: got %0d required 32", out_tag_rd);
        end
        tick();
        idle();
        vectors++;
        if (out_tag_rs[0] !== 6'd32 || out_tag_rs[1] !== 6'd32 || out_tag_rd !== 6'd33 ||
            free_count !== 6'd30 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second: got rs={%0d,%0d} rd=%0d free=%0d v=%0b required {32,32} 33 30 1",
                     out_tag_rs[0], out_tag_rs[1], out_tag_rd, free_count, out_valid);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: got valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_no_alloc();
        do_reset();
        drive(1'b1, 8'h30, 5, 6, 0, 1'b1);
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_tag_rd !== 6'd0 || out_rd_alloc !== 1'b0 ||
            out_tag_rs[0] !== 6'd5 || out_tag_rs[1] !== 6'd6 || free_count !== 6'd32) begin
            miscompares++;
            $display("FAIL x0_dest: got v=%0b rd=%0d alloc=%0b rs={%0d,%0d} free=%0d required 1 0 0 {5,6} 32",
                     out_valid, out_tag_rd, out_rd_alloc, out_tag_rs[0], out_tag_rs[1], free_count);
        end
        drive(1'b1, 8'h34, 8, 9, 7, 1'b0);
        tick();
        idle();
        vectors++;
        if (out_valid !== 1'b1 || out_tag_rd !== 6'd0 || out_rd_alloc !== 1'b0 ||
            out_arch_rd !== 5'd7 || free_count !== 6'd32) begin
            miscompares++;
            $display("FAIL store_no_rd: got v=%0b rd=%0d alloc=%0b ard=%0d free=%0d required 1 0 0 7 32",
                     out_valid, out_tag_rd, out_rd_alloc, out_arch_rd, free_count);
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1'b1, 8'h40, 1, 2, 5, 1'b1);
        tick();
        stall_in = 1'b1;
        drive(1'b1, 8'h44, 5, 1, 6, 1'b1);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_ready: got %0b required 0", in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 8'h40 || out_tag_rd !== 6'd32 || free_count !== 6'd31) begin
                miscompares++;
                $display("FAIL stall_hold_%0d: got v=%0b pc=%0h rd=%0d free=%0d required 1 40 32 31",
                         c, out_valid, out_pc, out_tag_rd, free_count);
            end
        end
        stall_in = 1'b0;
        #1;
        tick();
        idle();
        vectors++;
        if (out_pc !== 8'h44 || out_tag_rd !== 6'd33 || out_tag_rs[0] !== 6'd32 || free_count !== 6'd30) begin
            miscompares++;
            $display("FAIL stall_release: got pc=%0h rd=%0d rs0=%0d free=%0d required 44 33 32 30",
                     out_pc, out_tag_rd, out_tag_rs[0], free_count);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || free_count !== 6'd30) begin
            miscompares++;
            $display("FAIL stall_once: got v=%0b free=%0d required 0 30", out_valid, free_count);
        end
    endtask

    task automatic test_exhaust();
        do_reset();
        for (int k = 0; k < 32; k++) begin
            drive(1'b1, 8'(k), 0, 0, (k % 31) + 1, 1'b1);
            tick();
            vectors++;
            if (out_tag_rd !== 6'(32 + k)) begin
                miscompares++;
                $display("FAIL exhaust_alloc_%0d: got %0d required %0d", k, out_tag_rd, 32 + k);
            end
        end
        drive(1'b1, 8'h80, 0, 0, 5, 1'b1);
        vectors++;
        if (free_count !== 6'd0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL exhaust_empty: got free=%0d ready=%0b required 0 0", free_count, in_ready);
        end
        drive(1'b1, 8'h80, 0, 0, 5, 1'b0);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL exhaust_nowrite_ready: got %0b required 1", in_ready);
        end
        drive(1'b1, 8'h81, 0, 0, 5, 1'b1);
        retire_valid = 1'b1;
        retire_reg   = 5'd3;
        retire_tag   = 6'd32;
        tick();
        retire_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || free_count !== 6'd1 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL retire_free: got v=%0b free=%0d ready=%0b required 0 1 1",
                     out_valid, free_count, in_ready);
        end
        tick();
        idle();
        vectors++;
        if (out_valid !== 1'b1 || out_tag_rd !== 6'd3 || out_rd_alloc !== 1'b1 || free_count !== 6'd0) begin
            miscompares++;
            $display("FAIL realloc_freed: got v=%0b rd=%0d alloc=%0b free=%0d required 1 3 1 0",
                     out_valid, out_tag_rd, out_rd_alloc, free_count);
        end
    endtask

    task automatic test_wrap_simul();
        logic [5:0] exp_tag [5];
        exp_tag = '{6'd60, 6'd61, 6'd62, 6'd63, 6'd10};
        do_reset();
        for (int k = 0; k < 27; k++) begin
            drive(1'b1, 8'(k), 0, 0, k + 1, 1'b1);
            tick();
        end
        vectors++;
        if (free_count !== 6'd5) begin
            miscompares++;
            $display("FAIL wrap_pre_count: got %0d required 5", free_count);
        end
        drive(1'b1, 8'h90, 0, 0, 28, 1'b1);
        retire_valid = 1'b1;
        retire_reg   = 5'd10;
        retire_tag   = 6'd41;
        tick();
        retire_valid = 1'b0;
        vectors++;
        if (free_count !== 6'd5 || out_tag_rd !== 6'd59) begin
            miscompares++;
            $display("FAIL simul_pop_push: got free=%0d rd=%0d required 5 59", free_count, out_tag_rd);
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 8'hA0 + 8'(k), 28, 10, 29 + k, 1'b1);
            if (k >= 3) drive(1'b1, 8'hA0 + 8'(k), 28, 10, k - 2, 1'b1);
            tick();
            vectors++;
            if (out_tag_rd !== exp_tag[k] || free_count !== 6'(4 - k)) begin
                miscompares++;
                $display("FAIL wrap_order_%0d: got rd=%0d free=%0d required %0d %0d",
                         k, out_tag_rd, free_count, exp_tag[k], 4 - k);
            end
            if (k == 0) begin
                vectors++;
                if (out_tag_rs[0] !== 6'd59 || out_tag_rs[1] !== 6'd41) begin
                    miscompares++;
                    $display("FAIL wrap_lookup: got rs={%0d,%0d} required {59,41}",
                             out_tag_rs[0], out_tag_rs[1]);
                end
            end
        end
        idle();
        retire_valid = 1'b1;
        retire_reg   = 5'd0;
        retire_tag   = 6'd40;
        tick();
        retire_valid = 1'b0;
        vectors++;
        if (free_count !== 6'd0) begin
            miscompares++;
            $display("FAIL retire_x0_ignored: got free=%0d required 0", free_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        stall_in = 1'b0;
        retire_valid = 1'b0;
        retire_reg = '0;
        retire_tag = '0;
        in_valid = 1'b0;
        in_pc = '0;
        arch_rs[0] = '0;
        arch_rs[1] = '0;
        arch_rd = '0;
        rd_write = 1'b0;
        test_reset();
        test_basic_rename();
        test_back_to_back();
        test_no_alloc();
        test_stall();
        test_exhaust();
        test_wrap_simul();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
